// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, access
// size codes (funct3[1:0]) and the alignment helper used at accept time.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ISSUE,
    LSU_WAIT,
    LSU_RESP
  } lsu_state_t;

  localparam logic [1:0] LSU_B = 2'b00;
  localparam logic [1:0] LSU_H = 2'b01;
  localparam logic [1:0] LSU_W = 2'b10;

  // Half-words need ea[0] clear, words need ea[1:0] clear; bytes are always aligned.
  function automatic logic lsu_misaligned(input logic [1:0] oplen, input logic [1:0] ea_lo);
    case (oplen)
      LSU_H:   return ea_lo[0];
      LSU_W:   return (ea_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// lsu_extend: combinational load-data extension.
//   i_funct3     [1:0] size (byte/half/word), [2] unsigned
//   i_mem_result raw read word from the controller
//   o_data       byte/half from the low lane, sign- or zero-extended; word passed through
module lsu_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_mem_result,
  output logic [31:0] o_data
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = ~i_funct3[2] & i_mem_result[7];
  assign w_sign_h = ~i_funct3[2] & i_mem_result[15];

  always_comb begin
    o_data = i_mem_result;
    case (i_funct3[1:0])
      LSU_B:   o_data = {{24{w_sign_b}}, i_mem_result[7:0]};
      LSU_H:   o_data = {{16{w_sign_h}}, i_mem_result[15:0]};
      default: o_data = i_mem_result;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store execution between the execute stage and
// the sdramController data port. One access in flight.
//   req_*  : accept-side handshake (req_valid/req_ready), operands and rd tag
//   resp_* : one-cycle resp_valid pulse with extended data, rd tag and fault
//   mem_*  : enable/valid handshake with the controller
// Faults (misaligned, out of range, illegal size, timeout) respond without
// data; accept-time faults never start a memory cycle.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_imm,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_fault,
  output logic              mem_enable,
  input  logic              mem_valid,
  output logic              mem_rw,
  output logic [1:0]        mem_oplen,
  output logic              mem_unsigned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_result
);

  localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

  lsu_state_t        r_state;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_rw;
  logic [2:0]        r_funct3;
  logic [4:0]        r_rd;

  logic              r_resp_valid;
  logic [31:0]       r_resp_data;
  logic [4:0]        r_resp_rd;
  logic              r_resp_fault;
  logic              r_mem_enable;
  logic              r_mem_rw;
  logic [1:0]        r_mem_oplen;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [31:0]       w_ea;
  logic              w_fault;
  logic [31:0]       w_ext;
  logic [TMO_W-1:0]  w_tmo_inc;
  logic              w_tmo_hit;

  assign w_ea = req_base + req_imm;

  always_comb begin
    w_fault = (req_funct3[1:0] == 2'b11)
           || lsu_misaligned(req_funct3[1:0], w_ea[1:0])
           || ((w_ea >> ADDR_W) != '0);
  end

  // The counter is cleared on entering ISSUE and carries into WAIT, so the
  // bound covers the whole memory cycle rather than each phase separately.
  assign w_tmo_inc = r_tmo + 1'b1;
  assign w_tmo_hit = (w_tmo_inc == TMO_LIMIT);

  lsu_extend u_extend (
    .i_funct3     (r_funct3),
    .i_mem_result (mem_result),
    .o_data       (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= LSU_IDLE;
      r_tmo        <= '0;
      r_rw         <= 1'b0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
      r_resp_fault <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_oplen  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        LSU_IDLE: begin
          if (req_valid) begin
            r_rw     <= req_rw;
            r_funct3 <= req_funct3;
            r_rd     <= req_rd;
            if (w_fault) begin
              r_state      <= LSU_RESP;
              r_resp_valid <= 1'b1;
              r_resp_data  <= '0;
              r_resp_rd    <= req_rd;
              r_resp_fault <= 1'b1;
            end else begin
              r_state      <= LSU_ISSUE;
              r_tmo        <= '0;
              r_mem_enable <= 1'b1;
              r_mem_rw     <= req_rw;
              r_mem_oplen  <= req_funct3[1:0];
              r_mem_addr   <= w_ea[ADDR_W-1:0];
              r_mem_wdata  <= req_wdata;
            end
          end
        end
        LSU_ISSUE: begin
          if (!mem_valid) begin
            r_mem_enable <= 1'b0;
            r_state      <= LSU_WAIT;
          end else if (w_tmo_hit) begin
            r_mem_enable <= 1'b0;
            r_state      <= LSU_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
            r_resp_rd    <= r_rd;
            r_resp_fault <= 1'b1;
          end else begin
            r_tmo <= w_tmo_inc;
          end
        end
        LSU_WAIT: begin
          if (mem_valid) begin
            r_state      <= LSU_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= r_rw ? '0 : w_ext;
            r_resp_rd    <= r_rd;
            r_resp_fault <= 1'b0;
          end else if (w_tmo_hit) begin
            r_state      <= LSU_RESP;
            r_resp_valid <= 1'b1;
            r_resp_data  <= '0;
            r_resp_rd    <= r_rd;
            r_resp_fault <= 1'b1;
          end else begin
            r_tmo <= w_tmo_inc;
          end
        end
        LSU_RESP: begin
          r_state <= LSU_IDLE;
        end
        default: r_state <= LSU_IDLE;
      endcase
    end
  end

  assign req_ready    = (r_state == LSU_IDLE);
  assign resp_valid   = r_resp_valid;
  assign resp_data    = r_resp_data;
  assign resp_rd      = r_resp_rd;
  assign resp_fault   = r_resp_fault;
  assign mem_enable   = r_mem_enable;
  assign mem_rw       = r_mem_rw;
  assign mem_oplen    = r_mem_oplen;
  assign mem_unsigned = 1'b1;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (ADDR_W=25, TIMEOUT_CYC=8).
// Stimulus pushes the expected response; a negedge monitor pops and compares.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_imm;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_fault;
  logic        mem_enable;
  logic        mem_valid;
  logic        mem_rw;
  logic [1:0]  mem_oplen;
  logic        mem_unsigned;
  logic [24:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_result;

  load_store_unit #(.ADDR_W(25), .TIMEOUT_CYC(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rw       (req_rw),
    .req_funct3   (req_funct3),
    .req_base     (req_base),
    .req_imm      (req_imm),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_rd      (resp_rd),
    .resp_fault   (resp_fault),
    .mem_enable   (mem_enable),
    .mem_valid    (mem_valid),
    .mem_rw       (mem_rw),
    .mem_oplen    (mem_oplen),
    .mem_unsigned (mem_unsigned),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_result   (mem_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   c0 = 0;
  int   resp_cyc = 0;
  int   resp_cnt = 0;
  int   start_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every response against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_resp: got rd=%0d data=%h expected no response", resp_rd, resp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_data", 64'(resp_data), 64'(e.data));
        chk("resp_rd", 64'(resp_rd), 64'(e.rd));
        chk("resp_fault", 64'(resp_fault), 64'(e.fault));
      end
      resp_cyc = cyc;
      resp_cnt++;
    end
  end

  task automatic issue(input logic rw, input logic [2:0] f3, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] e_data, input logic e_fault, input logic expect_resp);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 64'(req_ready), 64'd1);
    if (expect_resp) begin
      e.data = e_data; e.rd = rd; e.fault = e_fault;
      q.push_back(e);
    end
    start_cnt  = resp_cnt;
    req_rw     = rw;
    req_funct3 = f3;
    req_base   = base;
    req_imm    = imm;
    req_wdata  = wdata;
    req_rd     = rd;
    req_valid  = 1'b1;
    c0         = cyc;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  // Controller model: check the request, go busy for 'lo' cycles, then finish with 'res'.
  task automatic serve(input int lo, input logic [31:0] res, input logic [24:0] e_addr,
                       input logic e_rw, input logic [1:0] e_oplen, input logic [31:0] e_wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_enable && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mem_enable", 64'(mem_enable), 64'd1);
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_ctl", 64'({mem_rw, mem_oplen, mem_unsigned}), 64'({e_rw, e_oplen, 1'b1}));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    mem_valid = 1'b0;
    repeat (lo) @(negedge clk);
    mem_result = res;
    mem_valid  = 1'b1;
  endtask

  task automatic wait_resp(input int lat, input logic no_mem);
    int   n;
    logic saw;
    n   = 0;
    saw = mem_enable;
    while (resp_cnt == start_cnt && n < 60) begin
      @(negedge clk);
      #1;
      saw = saw | mem_enable;
      n++;
    end
    chk("resp_arrived", 64'(resp_cnt - start_cnt), 64'd1);
    chk("resp_latency", 64'(resp_cyc - c0), 64'(lat));
    if (no_mem) chk("no_mem_cycle", 64'(saw), 64'd0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_resp", 64'({resp_valid, resp_fault, resp_rd, resp_data}), 64'd0);
    chk("rst_mem_ctl", 64'({mem_enable, mem_rw, mem_oplen, mem_unsigned}), 64'b00001);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_funct3 = '0;
    req_base = '0; req_imm = '0; req_wdata = '0; req_rd = '0;
    mem_valid = 1'b1; mem_result = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    // LW 0x100 + (-4)
    issue(1'b0, 3'b010, 32'h100, 32'hFFFF_FFFC, 32'h0, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1);
    serve(1, 32'hDEAD_BEEF, 25'h0FC, 1'b0, 2'd2, 32'h0);
    wait_resp(3, 1'b0);

    // LB / LBU / LH / LHU / LB positive
    issue(1'b0, 3'b000, 32'h200, 32'h1, 32'h0, 5'd6, 32'hFFFF_FF80, 1'b0, 1'b1);
    serve(2, 32'h0000_0080, 25'h201, 1'b0, 2'd0, 32'h0);
    wait_resp(4, 1'b0);
    issue(1'b0, 3'b100, 32'h200, 32'h1, 32'h0, 5'd7, 32'h0000_0080, 1'b0, 1'b1);
    serve(1, 32'h0000_0080, 25'h201, 1'b0, 2'd0, 32'h0);
    wait_resp(3, 1'b0);
    issue(1'b0, 3'b001, 32'h200, 32'h2, 32'h0, 5'd8, 32'hFFFF_8001, 1'b0, 1'b1);
    serve(1, 32'h0000_8001, 25'h202, 1'b0, 2'd1, 32'h0);
    wait_resp(3, 1'b0);
    issue(1'b0, 3'b101, 32'h200, 32'h2, 32'h0, 5'd9, 32'h0000_8001, 1'b0, 1'b1);
    serve(1, 32'hABCD_8001, 25'h202, 1'b0, 2'd1, 32'h0);
    wait_resp(3, 1'b0);
    issue(1'b0, 3'b000, 32'h300, 32'h0, 32'h0, 5'd10, 32'h0000_007F, 1'b0, 1'b1);
    serve(1, 32'h1234_567F, 25'h300, 1'b0, 2'd0, 32'h0);
    wait_resp(3, 1'b0);

    // Accept-time faults: misaligned, out of range, illegal size
    issue(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd11, 32'h0, 1'b1, 1'b1);
    wait_resp(1, 1'b1);
    issue(1'b0, 3'b001, 32'h100, 32'h3, 32'h0, 5'd12, 32'h0, 1'b1, 1'b1);
    wait_resp(1, 1'b1);
    issue(1'b1, 3'b010, 32'h0200_0000, 32'h0, 32'h1111_1111, 5'd13, 32'h0, 1'b1, 1'b1);
    wait_resp(1, 1'b1);
    issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 5'd14, 32'h0, 1'b1, 1'b1);
    wait_resp(1, 1'b1);

    // Range boundary: last word in range, and wrapped address 0
    issue(1'b0, 3'b010, 32'h01FF_FFFC, 32'h0, 32'h0, 5'd15, 32'hCAFE_F00D, 1'b0, 1'b1);
    serve(1, 32'hCAFE_F00D, 25'h1FF_FFFC, 1'b0, 2'd2, 32'h0);
    wait_resp(3, 1'b0);
    issue(1'b0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd16, 32'h0000_00A5, 1'b0, 1'b1);
    serve(1, 32'hFFFF_FFA5, 25'h0, 1'b0, 2'd0, 32'h0);
    wait_resp(3, 1'b0);

    // SH with a 3-cycle busy period
    issue(1'b1, 3'b001, 32'h10, 32'h0, 32'h1234_ABCD, 5'd7, 32'h0, 1'b0, 1'b1);
    serve(3, 32'hFFFF_FFFF, 25'h10, 1'b1, 2'd1, 32'h1234_ABCD);
    wait_resp(5, 1'b0);

    // WAIT timeout: busy never ends within 8 WAIT cycles
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd17, 32'h0, 1'b1, 1'b1);
    serve(12, 32'h5555_5555, 25'h40, 1'b0, 2'd2, 32'h0);
    wait_resp(10, 1'b0);
    chk("ready_after_wait_tmo", 64'(req_ready), 64'd1);

    // ISSUE timeout: controller never accepts
    issue(1'b0, 3'b010, 32'h44, 32'h0, 32'h0, 5'd18, 32'h0, 1'b1, 1'b1);
    wait_resp(9, 1'b0);
    chk("enable_after_issue_tmo", 64'(mem_enable), 64'd0);

    // Reset during ISSUE: mem_enable drops without a clock edge
    issue(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 5'd19, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("enable_in_issue", 64'(mem_enable), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst_issue", 64'(req_ready), 64'd1);

    // Reset during WAIT with non-zero response registers from a prior access
    issue(1'b0, 3'b010, 32'h84, 32'h0, 32'h0, 5'd21, 32'h1357_9BDF, 1'b0, 1'b1);
    serve(1, 32'h1357_9BDF, 25'h84, 1'b0, 2'd2, 32'h0);
    wait_resp(3, 1'b0);
    issue(1'b0, 3'b010, 32'h88, 32'h0, 32'h0, 5'd20, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    mem_valid = 1'b1;
    @(negedge clk);
    chk("ready_after_rst_wait", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
